// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: hex or unsigned-decimal rendering, dp, blink, PWM dimming, overflow dashes.
// Optional leading-zero blanking is compiled in with `define SEG7_LZ_SUPPRESS_EN.

module seg7_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       commit,
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  input  logic       ovf,
  input  logic       mask,
  output logic [7:0] seg
);
  logic [7:0] glyph;
  logic [7:0] disp;

  // Active-low {a,b,c,d,e,f,g,p}; p bit kept 1 here and replaced by the dp input.
  always_comb begin
    case (nib)
      4'h0:    glyph = 8'h03;
      4'h1:    glyph = 8'h9F;
      4'h2:    glyph = 8'h25;
      4'h3:    glyph = 8'h0D;
      4'h4:    glyph = 8'h99;
      4'h5:    glyph = 8'h49;
      4'h6:    glyph = 8'h41;
      4'h7:    glyph = 8'h1F;
      4'h8:    glyph = 8'h01;
      4'h9:    glyph = 8'h09;
      4'hA:    glyph = 8'h11;
      4'hB:    glyph = 8'hC1;
      4'hC:    glyph = 8'h63;
      4'hD:    glyph = 8'h85;
      4'hE:    glyph = 8'h61;
      default: glyph = 8'h71;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp <= '1;
      seg  <= '1;
    end else begin
      if (commit)
        disp <= ovf   ? 8'hFD :
                blank ? {7'h7F, ~dp} : {glyph[7:1], ~dp};
      seg <= mask ? 8'hFF : disp;
    end
  end
endmodule

module seg7_display_ctrl #(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 16,
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int PWM_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_mode,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PWM_W-1:0]      brightness,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [DIGITS*8-1:0]   seg,
  output logic                  overflow
);
  // Decimal digits needed for 2**DATA_W-1 (log10(2) ~ 0.30103).
  localparam int BCD_DIGITS  = (DATA_W * 30103) / 100000 + 1;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int HEX_DIGITS  = (DATA_W + 3) / 4;
  localparam int PAD_A       = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
  localparam int PADN        = (PAD_A > DIGITS) ? PAD_A : DIGITS;
  localparam int BLINK_DIV_R = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_DIV   = (BLINK_DIV_R < 1) ? 1 : BLINK_DIV_R;
  localparam int BLINK_CW    = $clog2(BLINK_DIV + 1);
  localparam int STEP_W      = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              mode;
    logic [DIGITS-1:0] dp;
  } req_t;

  state_t                 state, state_d;
  req_t                   req;
  logic [BCD_W-1:0]       bcd, bcd_adj;
  logic [DATA_W-1:0]      bin;
  logic [STEP_W-1:0]      step;
  logic                   accept, commit;
  logic [PADN*4-1:0]      hex_pad, bcd_pad;
  logic [PADN-1:0][3:0]   nib_all;
  logic                   ovf_calc;
  logic [DIGITS-1:0]      blank;
  logic [BLINK_CW-1:0]    blink_cnt;
  logic                   blink_phase;
  logic [PWM_W-1:0]       pwm_cnt;
  logic                   lit;
  logic [DIGITS-1:0]      mask;
  logic [DIGITS-1:0][7:0] seg_arr;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign commit   = (state == COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = in_mode ? CONVERT : COMMIT;
      CONVERT: if (step == STEP_W'(DATA_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble: add-3 on every BCD nibble >= 5, then shift one binary bit in.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req  <= '0;
      bin  <= '0;
      bcd  <= '0;
      step <= '0;
    end else if (accept) begin
      req  <= {in_data, in_mode, in_dp};
      bin  <= in_data;
      bcd  <= '0;
      step <= '0;
    end else if (state == CONVERT) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      step       <= step + STEP_W'(1);
    end
  end

  // Both sources padded to PADN nibbles so overflow is "any nibble at or above DIGITS set".
  always_comb begin
    hex_pad = '0;
    hex_pad[DATA_W-1:0] = req.data;
    bcd_pad = '0;
    bcd_pad[BCD_W-1:0]  = bcd;
    nib_all  = req.mode ? bcd_pad : hex_pad;
    ovf_calc = 1'b0;
    for (int i = DIGITS; i < PADN; i++)
      if (nib_all[i] != 4'd0) ovf_calc = 1'b1;
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen     = seen | (nib_all[i] != 4'd0);
      blank[i] = ~seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         overflow <= 1'b0;
    else if (commit) overflow <= ovf_calc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (blink_cnt == BLINK_CW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_CW'(1);
      end
    end
  end

  // All-ones brightness means always lit, so full duty is reachable.
  assign lit = (&brightness) | (pwm_cnt < brightness);

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign mask[g] = ~lit | (blink_phase & blink_en[g]);
      seg7_digit u_digit (
        .clk    (clk),
        .rst    (rst),
        .commit (commit),
        .nib    (nib_all[g]),
        .dp     (req.dp[g]),
        .blank  (blank[g]),
        .ovf    (ovf_calc),
        .mask   (mask[g]),
        .seg    (seg_arr[g])
      );
    end
  endgenerate

  assign seg = seg_arr;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench: two controllers (6 and 4 digits) share stimulus; a model predicts each committed image,
// a monitor checks them at commit, and a mask monitor checks blink/PWM masking cycle by cycle.

module tb_seg7_display_ctrl;
  localparam int DW = 16, CLKHZ = 16, BHZ = 1, BDIV = CLKHZ / (2 * BHZ);
  localparam logic [7:0] GLY [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  typedef struct {
    logic [63:0] img6;
    logic        ovf6;
    logic [63:0] img4;
    logic        ovf4;
    int          busy;
  } exp_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_mode = 1'b0, in_valid = 1'b0;
  logic [5:0]    in_dp = '0, blink_en = '0;
  logic [3:0]    brightness = 4'hF;
  logic          rdy6, rdy4, ovf6, ovf4;
  logic [47:0]   seg6;
  logic [31:0]   seg4;

  int          total = 0, bad = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] cur6 = 64'h0000_FFFF_FFFF_FFFF, cur4 = 64'h0000_0000_FFFF_FFFF;
  logic        mask_on = 1'b0;
  int          ecnt = 0;
  logic [3:0]  bri_rec = 4'hF;
  logic [5:0]  blk_rec = '0;
  logic        prev_rdy = 1'b1, pend = 1'b0;
  int          low_cnt = 0;

  seg7_display_ctrl #(.DIGITS(6), .DATA_W(DW), .CLK_HZ(CLKHZ), .BLINK_HZ(BHZ), .PWM_W(4)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_dp(in_dp),
    .in_valid(in_valid), .in_ready(rdy6), .brightness(brightness), .blink_en(blink_en),
    .seg(seg6), .overflow(ovf6));

  seg7_display_ctrl #(.DIGITS(4), .DATA_W(DW), .CLK_HZ(CLKHZ), .BLINK_HZ(BHZ), .PWM_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_dp(in_dp[3:0]),
    .in_valid(in_valid), .in_ready(rdy4), .brightness(brightness), .blink_en(blink_en[3:0]),
    .seg(seg4), .overflow(ovf4));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference: digit i of value v in base b is (v / b**i) % b; overflow when v >= b**nd.
  function automatic logic [63:0] model(input int nd, input logic [15:0] d, input logic m,
                                        input logic [7:0] dp, output logic ovf);
    longint base, v, p, lim;
    logic [63:0] img;
    base = m ? 10 : 16;
    v    = longint'(d);
    lim  = 1;
    for (int i = 0; i < nd; i++) lim = lim * base;
    ovf = (v >= lim);
    img = '0;
    p   = 1;
    for (int i = 0; i < nd; i++) begin
      int dig;
      logic [7:0] g;
      dig  = int'((v / p) % base);
      g    = GLY[dig];
      g[0] = ~dp[i];
      if (ovf) g = 8'hFD;
`ifdef SEG7_LZ_SUPPRESS_EN
      else if (i > 0 && v < p) g = {7'h7F, ~dp[i]};
`endif
      img[8*i +: 8] = g;
      p = p * base;
    end
    return img;
  endfunction

  task automatic send(input logic [15:0] d, input logic m, input logic [5:0] dp, input int hold);
    exp_t e;
    logic o6, o4;
    int tmo;
    tmo = 0;
    @(negedge clk);
    while (!rdy6 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (!rdy6) begin
      check("ready_timeout", rdy6, 1);
      return;
    end
    in_data  = d;
    in_mode  = m;
    in_dp    = dp;
    in_valid = 1'b1;
    e.img6 = model(6, d, m, {2'b00, dp}, o6);
    e.img4 = model(4, d, m, {4'b0000, dp[3:0]}, o4);
    e.ovf6 = o6;
    e.ovf4 = o4;
    e.busy = m ? DW + 1 : 1;
    sbq.push_back(e);
    @(negedge clk);
    for (int k = 0; k < hold; k++) begin
      in_data = 16'($urandom);
      in_mode = ~m;
      in_dp   = 6'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
    in_dp    = 6'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !rdy6) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rst) ecnt = 0;
    else     ecnt++;
    bri_rec = brightness;
    blk_rec = blink_en;
  end

  // Commit monitor: ready rising marks a commit; seg must follow one edge later.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b1;
      low_cnt  = 0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        check("seg6_new", seg6, cur6);
        check("seg4_new", seg4, cur4);
        pend = 1'b0;
      end
      if (!rdy6) low_cnt++;
      if (rdy6 && !prev_rdy) begin
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("busy_cycles", low_cnt, mon_e.busy);
          check("ready4", rdy4, 1);
          check("ovf6", ovf6, mon_e.ovf6);
          check("ovf4", ovf4, mon_e.ovf4);
          check("seg6_hold", seg6, cur6);
          check("seg4_hold", seg4, cur4);
          cur6 = mon_e.img6;
          cur4 = mon_e.img4;
          pend = 1'b1;
        end
        low_cnt = 0;
      end
      prev_rdy = rdy6;
    end
  end

  // Before edge n the PWM count is (n-1)%16 and the blink phase is ((n-1)/BDIV)%2.
  always @(negedge clk) begin
    int pc, ph;
    logic lit;
    logic [63:0] x6, x4;
    if (mask_on && !rst) begin
      pc  = (ecnt - 1) % 16;
      ph  = ((ecnt - 1) / BDIV) % 2;
      lit = (bri_rec == 4'hF) || (pc < int'(bri_rec));
      x6  = cur6;
      x4  = cur4;
      for (int i = 0; i < 6; i++) if (!lit || (blk_rec[i] && ph == 1)) x6[8*i +: 8] = 8'hFF;
      for (int i = 0; i < 4; i++) if (!lit || (blk_rec[i] && ph == 1)) x4[8*i +: 8] = 8'hFF;
      check("mask6", seg6, x6);
      check("mask4", seg4, x4);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg6", seg6, 48'hFFFF_FFFF_FFFF);
    check("rst_seg4", seg4, 32'hFFFF_FFFF);
    check("rst_ovf6", ovf6, 0);
    check("rst_ovf4", ovf4, 0);
    check("rst_ready", {rdy6, rdy4}, 2'b11);
    rst = 1'b0;

    send(16'h1A2F, 1'b0, 6'h00, 0);
    send(16'd65535, 1'b1, 6'h00, 10);
    send(16'd12345, 1'b1, 6'h05, 0);
    send(16'h00FF, 1'b0, 6'h00, 0);
    send(16'h0000, 1'b0, 6'h00, 0);
    send(16'h0100, 1'b0, 6'h10, 0);
    send(16'd10000, 1'b1, 6'h3F, 0);
    send(16'd9999, 1'b1, 6'h02, 3);
    send(16'hFFFF, 1'b0, 6'h21, 0);
    send(16'd0, 1'b1, 6'h01, 0);
    for (int k = 0; k < 25; k++) begin
      logic [15:0] d;
      logic m;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      m = 1'($urandom);
      send(d, m, 6'($urandom), m ? int'($urandom_range(0, 12)) : 0);
    end
    drain();

    send(16'h1A2F, 1'b0, 6'h08, 0);
    drain();
    mask_on = 1'b1;
    blink_en = 6'b000001;
    repeat (40) @(negedge clk);
    blink_en = '0;
    brightness = 4'd4;
    repeat (34) @(negedge clk);
    brightness = 4'd0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      brightness = 4'($urandom);
      blink_en   = 6'($urandom);
      @(negedge clk);
    end
    brightness = 4'hF;
    blink_en   = '0;
    repeat (3) @(negedge clk);
    mask_on = 1'b0;

    send(16'd12345, 1'b1, 6'h00, 0);
    drain();
    send(16'd54321, 1'b1, 6'h00, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_seg6", seg6, 48'hFFFF_FFFF_FFFF);
    check("abort_seg4", seg4, 32'hFFFF_FFFF);
    check("abort_ovf4", ovf4, 0);
    check("abort_ready", rdy6, 1);
    sbq.delete();
    cur6 = 64'h0000_FFFF_FFFF_FFFF;
    cur4 = 64'h0000_0000_FFFF_FFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_partial6", seg6, 48'hFFFF_FFFF_FFFF);
    check("no_partial_ovf", {ovf6, ovf4}, 2'b00);
    send(16'hBEEF, 1'b0, 6'h3F, 0);
    send(16'd321, 1'b1, 6'h00, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
